// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter among N requesters.
// Ownership is held for a whole message (up to the octet flagged by last),
// so messages never interleave on the line. One octet is in flight at a time.
module uart_tx_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned IDLE_MAX = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] data,
    input  logic [N-1:0]   last,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   grant,
    output logic           tx_wr,
    output logic [7:0]     tx_data,
    input  logic           tx_busy
);

    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;
    // A zero-width counter is not legal, so IDLE_MAX == 0 still gets one bit.
    localparam int unsigned CntW = (IDLE_MAX > 0) ? $clog2(IDLE_MAX + 1) : 1;
    localparam logic [CntW-1:0] IdleMax = CntW'(IDLE_MAX);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(N - 1);

    typedef enum logic [2:0] {StIdle, StOwn, StWrite, StHold, StDrain} state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] owner_q, owner_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tx_wr_q, tx_wr_d;
    logic [7:0]      tx_data_q, tx_data_d;

    logic            sel_found;
    logic [PtrW-1:0] sel_idx;
    logic [PtrW-1:0] cand;
    logic            accept;

    // Owner's octet is taken when it requests and the transmitter is free.
    assign accept  = (state_q == StOwn) && req[owner_q] && !tx_busy;
    assign ack     = accept ? grant_q : '0;
    assign grant   = grant_q;
    assign tx_wr   = tx_wr_q;
    assign tx_data = tx_data_q;

    // Round-robin search: first requesting index at or after ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < int'(N); k++) begin
            cand = PtrW'((int'(ptr_q) + k) % int'(N));
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Next-state logic for the message-locking arbitration FSM.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        tx_wr_d   = 1'b0;
        tx_data_d = tx_data_q;
        unique case (state_q)
            StIdle: begin
                grant_d = '0;
                if (sel_found) begin
                    owner_d          = sel_idx;
                    grant_d[sel_idx] = 1'b1;
                    ptr_d            = (sel_idx == LastIdx) ? '0 : sel_idx + 1'b1;
                    cnt_d            = '0;
                    state_d          = StOwn;
                end
            end
            StOwn: begin
                if (accept) begin
                    tx_data_d = data[{owner_q, 3'b000} +: 8];
                    last_d    = last[owner_q];
                    cnt_d     = '0;
                    tx_wr_d   = 1'b1;
                    state_d   = StWrite;
                end else if (!req[owner_q]) begin
                    // Owner went quiet for too long: abandon its message.
                    if (cnt_q == IdleMax) begin
                        grant_d = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWrite: state_d = StHold;
            // The transmitter's busy flag rises one cycle after wr; skip it here.
            StHold:  state_d = StDrain;
            StDrain: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_d = '0;
                        state_d = StIdle;
                    end else begin
                        state_d = StOwn;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; async reset leaves any in-flight frame alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            owner_q   <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            tx_wr_q   <= tx_wr_d;
            tx_data_q <= tx_data_d;
        end
    end

endmodule
